rop_req_unpacker: RTL and testbench

Serializes warp-wide ROP request entries (one per warp, NUM_LANES fragments with thread mask) into a stream of single-fragment requests for the depth/stencil/blend pipeline. It sits at the read end of the ROP request queue. It consumes one queue entry at a time and emits one fragment per active lane, in ascending lane order. Inactive lanes are skipped, so an entry with k active lanes costs exactly k output cycles.

---
 rtl/rop_req_unpacker.sv | 125 ++++++++++++
 tb/tb_rop_req_unpacker.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rop_req_unpacker.sv
// Serializes one warp-wide ROP request entry into single-fragment requests,
// one per active lane in ascending lane order, with overlap on the final lane.
module rop_req_unpacker #(
    parameter int NUM_LANES  = 4,
    parameter int DIM_BITS   = 16,
    parameter int DEPTH_BITS = 24,
    parameter int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    input  logic [NUM_LANES-1:0]           in_tmask,
    input  logic [NUM_LANES*DIM_BITS-1:0]  in_pos_x,
    input  logic [NUM_LANES*DIM_BITS-1:0]  in_pos_y,
    input  logic [NUM_LANES*32-1:0]        in_color,
    input  logic [NUM_LANES*DEPTH_BITS-1:0] in_depth,
    input  logic [NUM_LANES-1:0]           in_backface,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [LANE_BITS-1:0]           out_lane,
    output logic [DIM_BITS-1:0]            out_pos_x,
    output logic [DIM_BITS-1:0]            out_pos_y,
    output logic [31:0]                    out_color,
    output logic [DEPTH_BITS-1:0]          out_depth,
    output logic                           out_backface,
    output logic                           out_last,
    input  logic                           out_ready,
    output logic                           busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [NUM_LANES-1:0] pending_q, pending_d;
    logic                 alive_q;

    logic [DIM_BITS-1:0]   lane_x   [NUM_LANES];
    logic [DIM_BITS-1:0]   lane_y   [NUM_LANES];
    logic [31:0]           lane_c   [NUM_LANES];
    logic [DEPTH_BITS-1:0] lane_z   [NUM_LANES];

    logic [DIM_BITS-1:0]   pos_x_q  [NUM_LANES];
    logic [DIM_BITS-1:0]   pos_y_q  [NUM_LANES];
    logic [31:0]           color_q  [NUM_LANES];
    logic [DEPTH_BITS-1:0] depth_q  [NUM_LANES];
    logic [NUM_LANES-1:0]  backface_q;

    logic [LANE_BITS-1:0] cur_lane;
    logic                 one_left;
    logic                 out_fire;
    logic                 in_fire;

    // Entry buffer has no reset: its contents only matter once pending is loaded.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_x[gi] = in_pos_x[gi*DIM_BITS +: DIM_BITS];
        assign lane_y[gi] = in_pos_y[gi*DIM_BITS +: DIM_BITS];
        assign lane_c[gi] = in_color[gi*32 +: 32];
        assign lane_z[gi] = in_depth[gi*DEPTH_BITS +: DEPTH_BITS];

        always_ff @(posedge clk) begin
            if (in_fire) begin
                pos_x_q[gi]    <= lane_x[gi];
                pos_y_q[gi]    <= lane_y[gi];
                color_q[gi]    <= lane_c[gi];
                depth_q[gi]    <= lane_z[gi];
                backface_q[gi] <= in_backface[gi];
            end
        end
    end

    // Lowest pending lane wins: scan downward so the last match is the lowest.
    always_comb begin
        cur_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                cur_lane = LANE_BITS'(i);
            end
        end
    end

    assign one_left  = (pending_q != '0) &&
                       ((pending_q & (pending_q - NUM_LANES'(1))) == '0);
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = out_valid;
    assign out_last  = out_valid && one_left;
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = (state_q == S_IDLE) ? alive_q : (out_fire && one_left);
    assign in_fire   = in_valid && in_ready;

    assign out_lane     = cur_lane;
    assign out_pos_x    = pos_x_q[cur_lane];
    assign out_pos_y    = pos_y_q[cur_lane];
    assign out_color    = color_q[cur_lane];
    assign out_depth    = depth_q[cur_lane];
    assign out_backface = backface_q[cur_lane];

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        if (in_fire) begin
            pending_d = in_tmask;
            state_d   = (in_tmask != '0) ? S_DRAIN : S_IDLE;
        end else if (out_fire) begin
            pending_d = pending_q & ~(NUM_LANES'(1) << cur_lane);
            if (one_left) begin
                state_d = S_IDLE;
            end
        end
    end

    // alive_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            alive_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rop_req_unpacker.sv
// Randomized and directed checks of rop_req_unpacker against a fragment-queue model.
module tb_rop_req_unpacker;

    localparam int NL = 4;
    localparam int DB = 16;
    localparam int ZB = 24;
    localparam int LB = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [NL-1:0]     in_tmask = '0;
    logic [NL*DB-1:0]  in_pos_x = '0;
    logic [NL*DB-1:0]  in_pos_y = '0;
    logic [NL*32-1:0]  in_color = '0;
    logic [NL*ZB-1:0]  in_depth = '0;
    logic [NL-1:0]     in_backface = '0;
    logic              in_ready;
    logic              out_valid;
    logic [LB-1:0]     out_lane;
    logic [DB-1:0]     out_pos_x;
    logic [DB-1:0]     out_pos_y;
    logic [31:0]       out_color;
    logic [ZB-1:0]     out_depth;
    logic              out_backface;
    logic              out_last;
    logic              out_ready = 1'b0;
    logic              busy;

    rop_req_unpacker #(.NUM_LANES(NL), .DIM_BITS(DB), .DEPTH_BITS(ZB)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_tmask(in_tmask), .in_pos_x(in_pos_x),
        .in_pos_y(in_pos_y), .in_color(in_color), .in_depth(in_depth),
        .in_backface(in_backface), .in_ready(in_ready),
        .out_valid(out_valid), .out_lane(out_lane), .out_pos_x(out_pos_x),
        .out_pos_y(out_pos_y), .out_color(out_color), .out_depth(out_depth),
        .out_backface(out_backface), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [DB-1:0] x;
        logic [DB-1:0] y;
        logic [31:0]   c;
        logic [ZB-1:0] z;
        logic          bf;
        logic          last;
        int            cyc;
    } frag_t;

    frag_t exp_q[$];
    frag_t log_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    bit    up = 1'b0;
    bit    rand_ready = 1'b0;
    bit    ready_force = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) up <= 1'b0;
        else          up <= 1'b1;
    end

    // out_ready changes 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(3) != 0) : ready_force;
        end
    end

    // Model: every accepted entry becomes its active-lane fragments, in order.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_out_last", 64'(out_last), 64'd0);
        end else begin
            automatic bit   ev = (exp_q.size() != 0);
            automatic logic er;
            if (!up)      er = 1'b0;
            else if (!ev) er = 1'b1;
            else          er = out_ready && exp_q[0].last;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("busy", 64'(busy), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(er));
            if (ev && out_valid) begin
                automatic frag_t f = exp_q[0];
                chk("out_lane", 64'(out_lane), 64'(f.lane));
                chk("out_pos_x", 64'(out_pos_x), 64'(f.x));
                chk("out_pos_y", 64'(out_pos_y), 64'(f.y));
                chk("out_color", 64'(out_color), 64'(f.c));
                chk("out_depth", 64'(out_depth), 64'(f.z));
                chk("out_backface", 64'(out_backface), 64'(f.bf));
                chk("out_last", 64'(out_last), 64'(f.last));
                if (out_ready) begin
                    automatic frag_t g;
                    g.lane = int'(out_lane); g.x = out_pos_x; g.y = out_pos_y;
                    g.c = out_color; g.z = out_depth; g.bf = out_backface;
                    g.last = out_last; g.cyc = cyc;
                    log_q.push_back(g);
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < NL; i++) begin
                    if (in_tmask[i]) begin
                        automatic frag_t f;
                        f.lane = i;
                        f.x  = in_pos_x[i*DB +: DB];
                        f.y  = in_pos_y[i*DB +: DB];
                        f.c  = in_color[i*32 +: 32];
                        f.z  = in_depth[i*ZB +: ZB];
                        f.bf = in_backface[i];
                        f.last = ((in_tmask >> (i + 1)) == '0);
                        f.cyc = 0;
                        exp_q.push_back(f);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NL-1:0] m);
        int n = 0;
        in_tmask = m;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic set_directed(input logic [NL-1:0] bf);
        for (int i = 0; i < NL; i++) begin
            in_pos_x[i*DB +: DB] = 16'h0100 + 16'(i);
            in_pos_y[i*DB +: DB] = 16'h0200 + 16'(i);
            in_color[i*32 +: 32] = 32'h11223344 + 32'(i) * 32'h01010101;
            in_depth[i*ZB +: ZB] = 24'hABC000 + 24'(i);
        end
        in_backface = bf;
    endtask

    task automatic set_random();
        for (int i = 0; i < NL; i++) begin
            in_pos_x[i*DB +: DB] = DB'($urandom);
            in_pos_y[i*DB +: DB] = DB'($urandom);
            in_color[i*32 +: 32] = $urandom;
            in_depth[i*ZB +: ZB] = ZB'($urandom);
        end
        in_backface = NL'($urandom);
    endtask

    initial begin
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(2);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Sparse mask 1011
        ready_force = 1'b1;
        wait_cycles(1);
        log_q.delete();
        set_directed(4'b0000);
        send(4'b1011);
        wait_cycles(5);
        chk("sparse_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            chk("sparse_lane0", 64'(log_q[0].lane), 64'd0);
            chk("sparse_lane1", 64'(log_q[1].lane), 64'd1);
            chk("sparse_lane2", 64'(log_q[2].lane), 64'd3);
            chk("sparse_last_mid", 64'(log_q[1].last), 64'd0);
            chk("sparse_last_end", 64'(log_q[2].last), 64'd1);
            chk("sparse_x_lane3", 64'(log_q[2].x), 64'h0103);
            chk("sparse_contig", 64'(log_q[2].cyc - log_q[0].cyc), 64'd2);
        end

        // Empty mask
        log_q.delete();
        send(4'b0000);
        wait_cycles(3);
        chk("empty_count", 64'(log_q.size()), 64'd0);
        chk("empty_busy", 64'(busy), 64'd0);

        // Backpressure on mask 0110
        ready_force = 1'b0;
        wait_cycles(1);
        log_q.delete();
        set_directed(4'b0000);
        send(4'b0110);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_lane", 64'(out_lane), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        wait_cycles(4);
        chk("bp_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            chk("bp_first", 64'(log_q[0].lane), 64'd1);
            chk("bp_second", 64'(log_q[1].lane), 64'd2);
        end

        // Back-to-back A=1111, B=0001
        log_q.delete();
        set_directed(4'b0000);
        send(4'b1111);
        send(4'b0001);
        wait_cycles(4);
        chk("b2b_count", 64'(log_q.size()), 64'd5);
        if (log_q.size() == 5) begin
            chk("b2b_contig", 64'(log_q[4].cyc - log_q[0].cyc), 64'd4);
            chk("b2b_lane3", 64'(log_q[3].lane), 64'd3);
            chk("b2b_b0", 64'(log_q[4].lane), 64'd0);
            chk("b2b_b0_last", 64'(log_q[4].last), 64'd1);
        end

        // Full mask with backface only on lane 2
        log_q.delete();
        set_directed(4'b0100);
        send(4'b1111);
        wait_cycles(6);
        chk("full_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() == 4) begin
            chk("full_bf2", 64'(log_q[2].bf), 64'd1);
            chk("full_bf1", 64'(log_q[1].bf), 64'd0);
            chk("full_color3", 64'(log_q[3].c), 64'h14253647);
            chk("full_depth3", 64'(log_q[3].z), 64'hABC003);
            chk("full_y2", 64'(log_q[2].y), 64'h0202);
        end

        // Reset asserted mid-drain
        set_directed(4'b0000);
        send(4'b1111);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        log_q.delete();
        wait_cycles(5);
        chk("mid_rst_no_replay", 64'(log_q.size()), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);

        // Randomized entries with random backpressure
        rand_ready = 1'b1;
        for (int e = 0; e < 150; e++) begin
            set_random();
            if ($urandom_range(7) == 0) send(4'b0000);
            else                        send(NL'($urandom));
            if ($urandom_range(3) == 0) wait_cycles($urandom_range(3));
        end
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 2000) begin
                @(posedge clk);
                n++;
            end
            if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        end
        wait_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
